// File: rtl/int_regfile_sb.sv
// Integer register file with two read ports, two write ports and a busy scoreboard.
//
// Sits between decode/issue and writeback. Reads are combinational with write-first
// bypass from both write ports (wr1 has priority over wr0). Each register carries a
// busy bit: set when a producer is issued to it, cleared by writeback or flush.
// Issue logic must stall while rd_busy_* is set for any source or destination.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   rd_addr_a_i/b  read addresses
//   rd_data_a_o/b  read data (combinational, bypassed)
//   rd_busy_a_o/b  register has a pending producer not being written back this cycle
//   wr0_*_i        write port 0 (ALU writeback)
//   wr1_*_i        write port 1 (long-latency/memory writeback), wins over wr0
//   issue_en_i     mark issue_addr_i busy
//   issue_addr_i   destination register of the issued instruction
//   flush_i        clear all busy bits, except a same-cycle issue
//   busy_count_o   registered number of busy registers
module int_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic              rd_busy_a_o,
    output logic              rd_busy_b_o,

    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,

    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_count_o
);

    localparam int unsigned NREGS = 1 << ADDR_W;
    localparam bit          HasZero = (ZERO_REG != 0);

    // Storage and scoreboard state.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;

    // Qualified enables: with a hardwired zero register, anything aimed at r0 is dropped.
    logic wr0_ok, wr1_ok, issue_ok;

    always_comb begin
        wr0_ok   = wr0_en_i;
        wr1_ok   = wr1_en_i;
        issue_ok = issue_en_i;
        if (HasZero) begin
            if (wr0_addr_i == '0)   wr0_ok   = 1'b0;
            if (wr1_addr_i == '0)   wr1_ok   = 1'b0;
            if (issue_addr_i == '0) issue_ok = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: register contents, busy bits and their popcount
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            // wr1 applied last so it wins a same-address collision.
            if (wr0_ok && (wr0_addr_i == ADDR_W'(r))) regs_d[r] = wr0_data_i;
            if (wr1_ok && (wr1_addr_i == ADDR_W'(r))) regs_d[r] = wr1_data_i;
        end
    end

    always_comb begin
        busy_d       = busy_q;
        busy_count_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            // A new producer outranks both flush and writeback of the old one.
            if (issue_ok && (issue_addr_i == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if ((wr0_ok && (wr0_addr_i == ADDR_W'(r))) ||
                         (wr1_ok && (wr1_addr_i == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end
            busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[r]);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count_o = busy_count_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];
    logic              hit0    [2];
    logic              hit1    [2];

    assign rd_addr[0] = rd_addr_a_i;
    assign rd_addr[1] = rd_addr_b_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit0[p] = wr0_ok && (wr0_addr_i == rd_addr[p]);
            hit1[p] = wr1_ok && (wr1_addr_i == rd_addr[p]);

            if (hit1[p]) begin
                rd_data[p] = wr1_data_i;
            end else if (hit0[p]) begin
                rd_data[p] = wr0_data_i;
            end else begin
                rd_data[p] = regs_q[rd_addr[p]];
            end

            // A same-cycle writeback clears the hazard together with the bypassed data;
            // a same-cycle issue or flush is only seen after the edge.
            rd_busy[p] = busy_q[rd_addr[p]] && !(hit0[p] || hit1[p]);

            if (HasZero && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end

            // Bypass is combinational, so mask it explicitly while reset is held.
            if (!rst_ni) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data_a_o = rd_data[0];
    assign rd_data_b_o = rd_data[1];
    assign rd_busy_a_o = rd_busy[0];
    assign rd_busy_b_o = rd_busy[1];

endmodule

// File: doc/int_regfile_sb.md
Name: int_regfile_sb

Overview:
Parametrised successor to the integer register file. It has two read ports and two write ports (ALU and long-latency/memory writeback), with write-to-read bypass and a per-register busy scoreboard for in-order issue with out-of-order completion. It sits between decode/issue and the writeback stage; issue logic stalls on the busy flags it reports.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; NREGS = 2**ADDR_W registers
ZERO_REG, 1, when 1, register 0 is hardwired to zero, never written and never busy

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data (combinational, bypassed)
rd_data_b  output  DATA_W  read port B data (combinational, bypassed)
rd_busy_a  output  1  register at rd_addr_a has a pending producer
rd_busy_b  output  1  register at rd_addr_b has a pending producer
wr0_en  input  1  write port 0 (ALU) enable
wr0_addr  input  ADDR_W  write port 0 address
wr0_data  input  DATA_W  write port 0 data
wr1_en  input  1  write port 1 (long-latency/memory) enable
wr1_addr  input  ADDR_W  write port 1 address
wr1_data  input  DATA_W  write port 1 data
issue_en  input  1  mark issue_addr busy (new producer issued)
issue_addr  input  ADDR_W  destination register of issued instruction
flush  input  1  clear all busy bits (pipeline squash)
busy_count  output  ADDR_W+1  registered number of busy registers

Behaviour:
- Reset (reset low, asynchronous): all registers = 0, all busy bits = 0, busy_count = 0. While reset is held, rd_data_* = 0 and rd_busy_* = 0. No write, issue or flush takes effect while reset is low.
- Writes: on the rising edge, wrN_en=1 stores wrN_data at wrN_addr.
  - wr0 and wr1 to the same address in one cycle: wr1 wins.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Reads are combinational with write-first bypass.
  - If wr1_en and wr1_addr == rd_addr, return wr1_data.
  - Otherwise, if wr0_en and wr0_addr == rd_addr, return wr0_data.
  - Otherwise, return the stored value.
  - With ZERO_REG=1, address 0 always reads 0, regardless of bypass.
- Busy scoreboard: one bit per register, updated on the rising edge. Per-register next-state priority, highest first:
  - issue_en && issue_addr == r -> 1.
  - flush -> 0.
  - (wr0_en && wr0_addr == r) || (wr1_en && wr1_addr == r) -> 0.
  - Otherwise hold.
  - Consequences: issue and writeback to the same register in one cycle leaves it busy (new producer wins). Issue in a flush cycle survives the flush.
  - With ZERO_REG=1, issue to address 0 is ignored and bit 0 stays 0.
- rd_busy_x = stored busy bit AND NOT (a write to rd_addr_x this cycle on either port).
  - A same-cycle writeback therefore reports not-busy alongside the bypassed data.
  - A same-cycle issue is not visible until the next cycle.
  - A same-cycle flush does not mask rd_busy.
- busy_count: registered popcount of the next-state busy vector, so it always equals the popcount of the busy bits after the same edge. Range 0..NREGS (NREGS-1 when ZERO_REG=1); it never wraps.
- Writes and issues are accepted unconditionally; the scoreboard does no stall/ready handshake. Issue logic must stall while rd_busy is set for any source or the destination.
- Reset asserted mid-operation discards all pending state immediately. After release, the first rising edge processes inputs normally.

Test Plan:
- Reset, then drive wr0_en=1, wr0_addr=5, wr0_data=0xDEADBEEF, and rd_addr_a=5 in the same cycle -> rd_data_a=0xDEADBEEF combinationally. After the edge, with wr0_en=0, rd_data_a is still 0xDEADBEEF.
- Same cycle: wr0 (addr 7, 0x11111111) and wr1 (addr 7, 0x22222222) -> bypass returns 0x22222222, and the stored value after the edge is 0x22222222.
- issue_en to addr 3 -> next cycle rd_busy_a(3)=1 and busy_count=1. Then wr1 to addr 3 with 0xCAFE -> same cycle rd_busy_a=0 and rd_data_a=0xCAFE; next cycle busy_count=0.
- Addr 9 busy. Same cycle: issue_en to addr 9 and wr0 to addr 9 -> after the edge, addr 9 is still busy and busy_count is unchanged.
- Issue to addrs 1, 2 and 4 (busy_count=3). Then flush=1 together with issue_en to addr 6 -> next cycle only addr 6 is busy and busy_count=1.
- With ZERO_REG=1: write 0xFFFFFFFF to addr 0 and issue to addr 0 -> rd_data=0 and rd_busy=0, busy_count unchanged. Assert reset mid-sequence between clock edges -> all busy flags and data read 0 immediately.
